// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the RAM responder and the SPI initiator.
//   - opcode constants for the serial RAM command set
//   - responder FSM state encoding
//   - small opcode decode helpers
package spi_pkg;

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    READ,
    WRITE,
    RDSR,
    IGNORE
  } spi_state_t;

  // State that follows a fully received opcode byte.
  function automatic spi_state_t opcode_next_state(input logic [7:0] op);
    case (op)
      OP_READ, OP_WRITE: return ADDR_HI;
      OP_RDSR:           return RDSR;
      default:           return IGNORE;
    endcase
  endfunction

  // WRSR is accepted (and then ignored); anything unlisted is an error.
  function automatic logic opcode_is_known(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) ||
           (op == OP_RDSR) || (op == OP_WRSR);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with edge pulses.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (chain loads RESET_VAL)
//   din    : asynchronous input
//   level  : synchronized level
//   rise   : one-cycle pulse when level goes 0->1
//   fall   : one-cycle pulse when level goes 1->0
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial RAM responder (MSB first) bridging to a simple
// synchronous memory port.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi  : SPI inputs, asynchronous to clk
//   miso, miso_oe     : SPI data out and its pad enable
//   mem_addr          : byte address for both strobes
//   mem_wdata, mem_we : write data and one-cycle write strobe
//   mem_re, mem_rdata : one-cycle read strobe; data returns 1 clk later
//   cmd_err           : one-cycle pulse on an unsupported opcode
// Commands: 03 (read), 02 (write), 05 (status read), 01 (ignored).
module spi_ram_responder
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] STATUS_VAL  = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        cmd_err
);

  // ---------------------------------------------------------------- sync
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi gets the same depth as sclk so the sampled bit lines up with
  // the detected rising edge.
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_reg <= '0;
    end else begin
      mosi_sync_reg[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_reg[i] <= mosi_sync_reg[i-1];
      end
    end
  end

  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // The synchronizer chains come out of reset holding their reset values,
  // not the pins. settle_reg marks when the chains reflect the real pins;
  // only then can cs_n be trusted as "seen high", which arms the block.
  // A frame already in progress when reset is released is thereby ignored.
  logic [SYNC_STAGES:0] settle_reg;
  logic                 settled;
  logic                 armed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg <= '0;
    end else begin
      settle_reg <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign settled = settle_reg[SYNC_STAGES];

  // ---------------------------------------------------------------- FSM
  spi_state_t  state_reg, state_next;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_in_reg;
  logic [7:0]  shift_out_reg;
  logic [7:0]  byte_in;
  logic        rx_last;
  logic        is_read_reg;
  logic        cmd_err_next;

  assign byte_in = {shift_in_reg, mosi_s};
  assign rx_last = sclk_rise && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cmd_err_next = 1'b0;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (cs_fall && armed_reg) state_next = CMD;
        CMD: begin
          if (rx_last) begin
            state_next   = opcode_next_state(byte_in);
            cmd_err_next = !opcode_is_known(byte_in);
          end
        end
        ADDR_HI: if (rx_last) state_next = ADDR_LO;
        ADDR_LO: if (rx_last) state_next = is_read_reg ? READ : WRITE;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ datapath
  logic [15:0] addr_reg;
  logic [7:0]  mem_wdata_reg;
  logic        mem_we_reg, mem_re_reg, rd_load_reg;
  logic        miso_reg, miso_oe_reg, cmd_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg     <= 1'b0;
      bit_cnt_reg   <= '0;
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      is_read_reg   <= 1'b0;
      addr_reg      <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      rd_load_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      mem_we_reg  <= 1'b0;
      mem_re_reg  <= 1'b0;
      cmd_err_reg <= cmd_err_next;
      rd_load_reg <= mem_re_reg;
      miso_oe_reg <= (state_next != IDLE);

      // Arm only from an idle mode-0 bus: cs_n high with sclk low.
      if (settled && cs_level && !sclk_level) armed_reg <= 1'b1;

      // Post-increment after each write strobe so the strobe itself
      // carries the address the byte belongs to.
      if (mem_we_reg) addr_reg <= addr_reg + 16'd1;

      // Read data arrives one clk after the strobe cycle.
      if (rd_load_reg) shift_out_reg <= mem_rdata;

      if (state_reg == IDLE || state_next == IDLE) begin
        // Entering or leaving a frame; an unfinished write byte is dropped.
        bit_cnt_reg <= '0;
        miso_reg    <= 1'b0;
      end else if (sclk_rise) begin
        case (state_reg)
          CMD, ADDR_HI, ADDR_LO, WRITE: begin
            shift_in_reg <= byte_in[6:0];
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          end
          default: ;
        endcase
        if (rx_last) begin
          case (state_reg)
            CMD: begin
              is_read_reg   <= (byte_in == OP_READ);
              shift_out_reg <= STATUS_VAL;
            end
            ADDR_HI: addr_reg[15:8] <= byte_in;
            ADDR_LO: begin
              addr_reg[7:0] <= byte_in;
              mem_re_reg    <= is_read_reg;
            end
            WRITE: begin
              mem_we_reg    <= 1'b1;
              mem_wdata_reg <= byte_in;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall) begin
        case (state_reg)
          READ, RDSR: begin
            // Rotating keeps the status byte cycling; in READ the
            // register is reloaded before the next byte anyway.
            miso_reg      <= shift_out_reg[7];
            shift_out_reg <= {shift_out_reg[6:0], shift_out_reg[7]};
          end
          default: miso_reg <= 1'b0;
        endcase
        if (state_reg == READ) begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            addr_reg   <= addr_reg + 16'd1;
            mem_re_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign miso      = miso_reg & miso_oe_reg;
  assign miso_oe   = miso_oe_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign mem_re    = mem_re_reg;
  assign cmd_err   = cmd_err_reg;

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs_n and mosi.
REQ-002 Parameter STATUS_VAL, default 8'h40: byte returned by RDSR (sequential mode).
REQ-003 clk  in  1  system clock; one clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 sclk  in  1  SPI clock from the initiator, asynchronous to clk.
REQ-006 cs_n  in  1  SPI chip select, active-low.
REQ-007 mosi  in  1  SPI serial data from the initiator.
REQ-008 miso  out  1  SPI serial data to the initiator.
REQ-009 miso_oe  out  1  miso pad output enable; high only while selected.
REQ-010 mem_addr  out  16  memory byte address.
REQ-011 mem_wdata  out  8  memory write data.
REQ-012 mem_we  out  1  one-cycle write strobe.
REQ-013 mem_re  out  1  one-cycle read strobe.
REQ-014 mem_rdata  in  8  read data, valid exactly 1 clk after mem_re.
REQ-015 cmd_err  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-016 The block SHALL implement SPI mode 0, MSB first: mosi sampled on sclk rising, miso changed on sclk falling.
REQ-017 The block SHALL detect sclk and cs_n edges on the synchronized signals; sclk high and low phases are each at least 4 clk.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, RDSR, IGNORE.
REQ-019 On cs_n falling, the FSM SHALL go IDLE->CMD and clear the bit counter.
REQ-020 After 8 bits in CMD, the opcode SHALL select the next state: 0x03->ADDR_HI (read), 0x02->ADDR_HI (write), 0x05->RDSR, 0x01->IGNORE without error, any other->IGNORE with a cmd_err pulse.
REQ-021 ADDR_HI and ADDR_LO SHALL each shift 8 bits into a 16-bit address, then go to READ or WRITE.
REQ-022 READ: on the clk after the 24th rising edge, the block SHALL pulse mem_re with mem_addr equal to the address, and SHALL load mem_rdata into the shift register on the following clk.
REQ-023 READ: bit 7 SHALL appear on miso at the next sclk falling edge; after each 8th falling edge the address SHALL increment and a new read SHALL be issued.
REQ-024 WRITE: after every 8th mosi bit, the block SHALL pulse mem_we for 1 clk with the byte on mem_wdata and the current address, then increment the address.
REQ-025 The address SHALL wrap from 0xFFFF to 0x0000.
REQ-026 RDSR SHALL shift STATUS_VAL out repeatedly until cs_n rises.
REQ-027 IGNORE SHALL discard all bits and hold miso at 0 until cs_n rises.
REQ-028 On cs_n rising in any state, the FSM SHALL go to IDLE on the next clk, a partial write byte SHALL be discarded (no mem_we), and miso_oe SHALL go to 0.
REQ-029 mem_we and mem_re SHALL never be asserted together, and neither SHALL be asserted while in IDLE.
REQ-030 miso SHALL be 0 whenever miso_oe is 0.

Reset
REQ-031 While rst_n is low, the block SHALL hold: state IDLE; miso, miso_oe, mem_we, mem_re, cmd_err at 0; mem_addr at 0x0000; mem_wdata at 0x00; synchronizer flops with cs_n=1 and sclk=0.
REQ-032 After rst_n deasserts while cs_n is low, the block SHALL ignore the transaction until cs_n has been seen high.

Structure
REQ-033 Opcode constants (READ, WRITE, RDSR, WRSR) and the state enum SHALL live in the shared package spi_pkg, which the spi initiator also uses.
REQ-034 The block SHALL contain one sub-module, spi_sync_edge: a parameterized synchronizer with rise/fall pulse outputs, instantiated for sclk and cs_n.

Verification
REQ-035 Write transaction: cs_n low, send 02 12 34 AB CD, cs_n high -> mem_we at 0x1234=0xAB, then at 0x1235=0xCD; exactly 2 strobes.
REQ-036 Read transaction: memory preloaded with 0x1234=0x5A, 0x1235=0xC3; send 03 12 34 plus 16 dummy clocks -> miso bytes 0x5A, 0xC3.
REQ-037 Wrap: read from 0xFFFF with 2 data bytes -> mem_re at 0xFFFF, then at 0x0000.
REQ-038 Bad opcode 0x9F -> one cmd_err pulse, miso=0 for the rest of the frame, no mem_re/mem_we.
REQ-039 Abort: cs_n rises after 5 bits of a write data byte -> no mem_we, state IDLE; the next frame 05 + 8 clocks -> miso returns 0x40.
REQ-040 Reset mid-read: rst_n pulsed low during READ -> all outputs at reset values; no mem_re until a new cs_n falling edge.
